// File: rtl/int_arbiter_if.sv
// Handshake bundle between the interrupt arbiter and its CPU-side environment.
// master drives requests/strobes, slave (the arbiter) drives status and the CPU request.
interface int_arbiter_if;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       inta;
    logic       eoi;
    logic       pulse;
    logic [1:0] vec;
    logic [3:0] pend;
    logic [3:0] isr;
    logic [3:0] mask;
    logic       spur;

    modport master (
        output irq, mask_we, mask_d, inta, eoi,
        input  pulse, vec, pend, isr, mask, spur
    );

    modport slave (
        input  irq, mask_we, mask_d, inta, eoi,
        output pulse, vec, pend, isr, mask, spur
    );
endinterface

// File: rtl/int_arbiter.sv
// Four-source priority interrupt arbiter with edge-detected pending, in-service nesting and masking.
// PULSE rises 2 edges after an IRQ rise; the CPU holds off via INTA timing, withdrawal drops PULSE next cycle.
module int_arbiter (
    input  logic          t3,
    input  logic          clr,
    int_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t     state, state_n;
    logic [3:0] irq_q, pend_q, isr_q, mask_q;
    logic [1:0] vec_q, vec_n;
    logic       spur_q;

    logic [3:0] rise, prio_ok, elig, eoi_clr, inta_set;
    logic [1:0] elig_idx;
    logic       inta_ack;

    assign rise    = bus.irq & ~irq_q;
    // Lowest set in-service bit is the one an EOI retires.
    assign eoi_clr = isr_q & (~isr_q + 4'd1);

    always_comb begin
        prio_ok = 4'b1111;
        casez (isr_q)
            4'b???1: prio_ok = 4'b0000;
            4'b??10: prio_ok = 4'b0001;
            4'b?100: prio_ok = 4'b0011;
            4'b1000: prio_ok = 4'b0111;
            default: prio_ok = 4'b1111;
        endcase
    end

    assign elig = pend_q & ~mask_q & prio_ok;

    always_comb begin
        elig_idx = 2'd0;
        casez (elig)
            4'b???1: elig_idx = 2'd0;
            4'b??10: elig_idx = 2'd1;
            4'b?100: elig_idx = 2'd2;
            4'b1000: elig_idx = 2'd3;
            default: elig_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_n  = state;
        vec_n    = vec_q;
        inta_ack = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_n = REQ;
                    vec_n   = elig_idx;
                end
            end
            REQ: begin
                if (bus.inta) begin
                    inta_ack = 1'b1;
                    state_n  = IDLE;
                end else if (!(pend_q[vec_q] && !mask_q[vec_q])) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign inta_set = inta_ack ? (4'b0001 << vec_q) : 4'b0000;

    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            vec_q <= 2'd0;
        end else begin
            state <= state_n;
            vec_q <= vec_n;
        end
    end

    // A new IRQ edge on the acknowledged bit wins over the INTA clear.
    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            irq_q  <= 4'b0000;
            pend_q <= 4'b0000;
            isr_q  <= 4'b0000;
            mask_q <= 4'b1111;
            spur_q <= 1'b0;
        end else begin
            irq_q  <= bus.irq;
            pend_q <= (pend_q & ~inta_set) | rise;
            isr_q  <= (isr_q & ~(bus.eoi ? eoi_clr : 4'b0000)) | inta_set;
            if (bus.mask_we) begin
                mask_q <= bus.mask_d;
            end
            if ((bus.eoi && isr_q == 4'b0000) || (bus.inta && state == IDLE)) begin
                spur_q <= 1'b1;
            end
        end
    end

    assign bus.pulse = (state == REQ);
    assign bus.vec   = vec_q;
    assign bus.pend  = pend_q;
    assign bus.isr   = isr_q;
    assign bus.mask  = mask_q;
    assign bus.spur  = spur_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Scoreboard bench for int_arbiter: a per-source reference model queues the expected outputs
// every edge and an independent monitor pops and compares them; directed scenarios then random traffic.
module tb_int_arbiter;

    logic t3;
    logic clr;
    int_arbiter_if bus ();

    int_arbiter dut (
        .t3  (t3),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic       pulse;
        logic [1:0] vec;
        logic [3:0] pend;
        logic [3:0] isr;
        logic [3:0] mask;
        logic       spur;
    } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad   = 0;

    bit m_pend[4];
    bit m_isr[4];
    bit m_mask[4];
    bit m_irq_prev[4];
    bit m_req;
    int m_vec;
    bit m_spur;

    initial begin
        t3 = 1'b0;
        forever #5 t3 = ~t3;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: reasons per source index, following the arbitration rules directly.
    always @(posedge t3) begin
        snap_t s;
        int top;
        int pick;
        bit was_req;
        int was_vec;
        bit spur_now;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0; m_isr[i] = 0; m_mask[i] = 1; m_irq_prev[i] = 0;
            end
            m_req = 0; m_vec = 0; m_spur = 0;
        end else begin
            was_req = m_req;
            was_vec = m_vec;
            top = 4;
            for (int i = 3; i >= 0; i--) if (m_isr[i]) top = i;
            pick = -1;
            for (int i = 0; i < top; i++)
                if (pick < 0 && m_pend[i] && !m_mask[i]) pick = i;

            spur_now = (bus.eoi && top == 4) || (bus.inta && !was_req);
            if (bus.eoi && top < 4) m_isr[top] = 0;
            if (was_req && bus.inta) begin
                m_isr[was_vec] = 1;
                m_pend[was_vec] = 0;
            end
            if (!was_req) begin
                if (pick >= 0) begin
                    m_req = 1;
                    m_vec = pick;
                end
            end else if (bus.inta) begin
                m_req = 0;
            end else if (!(m_pend[was_vec] && !m_mask[was_vec])) begin
                m_req = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.irq[i] && !m_irq_prev[i]) m_pend[i] = 1;
                m_irq_prev[i] = bus.irq[i];
                if (bus.mask_we) m_mask[i] = bus.mask_d[i];
            end
            if (spur_now) m_spur = 1;
        end
        s.pulse = m_req;
        s.vec   = 2'(m_vec);
        s.spur  = m_spur;
        for (int i = 0; i < 4; i++) begin
            s.pend[i] = m_pend[i];
            s.isr[i]  = m_isr[i];
            s.mask[i] = m_mask[i];
        end
        exp_q.push_back(s);
    end

    always @(posedge t3) begin
        snap_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("pulse", int'(bus.pulse), int'(e.pulse));
            chk("vec",   int'(bus.vec),   int'(e.vec));
            chk("pend",  int'(bus.pend),  int'(e.pend));
            chk("isr",   int'(bus.isr),   int'(e.isr));
            chk("mask",  int'(bus.mask),  int'(e.mask));
            chk("spur",  int'(bus.spur),  int'(e.spur));
        end
    end

    task automatic tick(input logic [3:0] irq, input logic we, input logic [3:0] d,
                        input logic ia, input logic eo);
        @(negedge t3);
        bus.irq     = irq;
        bus.mask_we = we;
        bus.mask_d  = d;
        bus.inta    = ia;
        bus.eoi     = eo;
    endtask

    task automatic wait_req(input logic [3:0] irq);
        int n;
        n = 0;
        while (!m_req && n < 6) begin
            tick(irq, 1'b0, 4'b0000, 1'b0, 1'b0);
            n++;
        end
        if (!m_req) chk("req_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pulse"}, int'(bus.pulse), 0);
        chk({tag, "_vec"},   int'(bus.vec),   0);
        chk({tag, "_pend"},  int'(bus.pend),  0);
        chk({tag, "_isr"},   int'(bus.isr),   0);
        chk({tag, "_mask"},  int'(bus.mask),  15);
        chk({tag, "_spur"},  int'(bus.spur),  0);
    endtask

    initial begin
        logic [3:0] r_irq;
        logic       r_we, r_ia, r_eo;
        logic [3:0] r_d;

        clr = 1'b1;
        bus.irq = 4'b0000; bus.mask_we = 1'b0; bus.mask_d = 4'b0000;
        bus.inta = 1'b0;   bus.eoi = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge t3);
        @(negedge t3);
        clr = 1'b0;

        // Unmask everything, then a single rise on source 2.
        tick(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b0100);
        chk("basic_vec", int'(bus.vec), 2);
        chk("basic_pulse", int'(bus.pulse), 1);
        tick(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("basic_isr", int'(bus.isr), 4);
        chk("basic_pend", int'(bus.pend), 0);

        // Nested higher-priority request on source 0.
        tick(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b0101);
        chk("nest_vec", int'(bus.vec), 0);
        tick(4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("nest_isr", int'(bus.isr), 5);
        tick(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1);
        tick(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("nest_eoi_isr", int'(bus.isr), 4);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

        // Simultaneous rises on 3 and 1: 1 first, 3 blocked until EOI.
        tick(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b1010);
        chk("pair_first_vec", int'(bus.vec), 1);
        tick(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0);
        repeat (3) tick(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("pair_blocked_pulse", int'(bus.pulse), 0);
        tick(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1);
        wait_req(4'b1010);
        chk("pair_second_vec", int'(bus.vec), 3);
        tick(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

        // Withdrawal by masking, then re-request on unmask.
        tick(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b0100);
        tick(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
        repeat (2) tick(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("wd_pulse", int'(bus.pulse), 0);
        chk("wd_pend", int'(bus.pend), 4);
        chk("wd_isr", int'(bus.isr), 0);
        tick(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b0100);
        chk("wd_rereq_vec", int'(bus.vec), 2);
        tick(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

        // Spurious INTA in IDLE, then spurious EOI with nothing in service.
        tick(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("spur_inta", int'(bus.spur), 1);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Level held high: a single pending set only.
        tick(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b0010);
        tick(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1);
        repeat (7) tick(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("level_pend", int'(bus.pend), 0);

        // Asynchronous clear in the middle of a request.
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_req(4'b0001);
        @(negedge t3);
        #2 clr = 1'b1;
        #1;
        check_reset_outputs("async_clr");
        @(negedge t3);
        clr = 1'b0;
        tick(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);

        // Random traffic.
        r_irq = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
            r_we = ($urandom_range(0, 19) == 0);
            r_d  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            r_ia = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            r_eo = ($urandom_range(0, 7) == 0);
            tick(r_irq, r_we, r_d, r_ia, r_eo);
        end
        tick(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge t3);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
